urv_console_uart: RTL and testbench

- Memory-mapped console UART that sits on the uRV CPU data-memory bus, downstream of the core's store/load strobes.
- Decodes a 16-byte window at g_base_addr and buffers written bytes in a FIFO.
- Serialises them as 8N1 on txd_o.
- Provides a status/control register and a level interrupt for the "TX drained" condition.

---
 rtl/urv_console_pkg.sv | 30 +++
 rtl/urv_sync_fifo.sv | 71 +++++++
 rtl/urv_console_uart.sv | 260 ++++++++++++++++++++++++++
 tb/tb_urv_console_uart.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/urv_console_pkg.sv
// Shared definitions for the uRV console UART.
//
// Holds the register offsets inside the 16-byte window, the bit positions
// of the STATUS and CTRL registers, and the serializer state type.
package urv_console_pkg;

  // Register offsets within the 16-byte window (full nibble compared)
  localparam logic [3:0] REG_TXDATA   = 4'h0;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_CTRL     = 4'h8;
  localparam logic [3:0] REG_RESERVED = 4'hC;

  // STATUS register fields
  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_LEVEL_LSB = 8;

  // CTRL register fields
  localparam int CTRL_IRQ_EN_BIT = 0;

  // Serializer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/urv_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data.
//
// Ports:
//   clk_i    - clock
//   rst_n_i  - asynchronous active-low reset (clears pointers and level)
//   push_i   - write data_i this cycle (caller guarantees !full or pop_i)
//   data_i   - write data
//   pop_i    - drop the head entry this cycle (caller guarantees !empty)
//   data_o   - current head entry
//   full_o   - level equals depth
//   empty_o  - level is zero
//   level_o  - number of stored entries, clog2(depth)+1 bits
//
// g_depth must be a power of two so the pointers wrap naturally.
module urv_sync_fifo #(
  parameter int g_width = 8,
  parameter int g_depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push_i,
  input  logic [g_width-1:0]         data_i,
  input  logic                       pop_i,
  output logic [g_width-1:0]         data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(g_depth):0]   level_o
);

  localparam int AW = $clog2(g_depth);

  logic [g_width-1:0] mem [g_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        level;

  // Storage is not reset; only pointers and level define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_i) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop keeps the level unchanged.
      case ({push_i, pop_i})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr];
  // Depth is a power of two, so the MSB of the level is set only when full.
  assign full_o  = level[AW];
  assign empty_o = (level == '0);
  assign level_o = level;

endmodule

// File: rtl/urv_console_uart.sv
// Memory-mapped 8N1 console UART for the uRV data-memory bus.
//
// Ports:
//   clk_i            - system clock
//   rst_n_i          - asynchronous active-low reset (released synchronously)
//   dm_addr_i        - byte address from the core
//   dm_data_s_i      - store data
//   dm_data_select_i - store byte lanes
//   dm_store_i       - one-cycle store strobe
//   dm_load_i        - one-cycle load strobe
//   dm_data_l_o      - load data, held until the next load
//   dm_store_done_o  - store accepted pulse
//   dm_load_done_o   - load data valid pulse
//   txd_o            - serial output, idle high
//   irq_o            - level interrupt: irq_en & FIFO empty & serializer idle
//
// Registers: 0x0 TXDATA (WO), 0x4 STATUS (RO), 0x8 CTRL (RW), 0xC reserved.
module urv_console_uart
  import urv_console_pkg::*;
#(
  parameter logic [31:0] g_base_addr  = 32'h0010_0000,
  parameter int          g_fifo_depth = 16,
  parameter int          g_baud_div   = 868
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_store_done_o,
  output logic        dm_load_done_o,
  output logic        txd_o,
  output logic        irq_o
);

  localparam int          LW        = $clog2(g_fifo_depth) + 1;
  localparam int          BW        = $clog2(g_baud_div);
  localparam logic [BW-1:0] BAUD_LAST = BW'(g_baud_div - 1);

  // Reset synchronizer: asserts asynchronously, releases on the clock.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Bus decode
  logic       hit;
  logic [3:0] offset;
  logic       st_new;
  logic       st_push_req;
  logic       ctrl_wr;
  logic       ld_new;

  assign hit         = (dm_addr_i[31:4] == g_base_addr[31:4]);
  assign offset      = dm_addr_i[3:0];
  assign st_new      = dm_store_i & hit;
  assign st_push_req = st_new & (offset == REG_TXDATA) & dm_data_select_i[0];
  assign ctrl_wr     = st_new & (offset == REG_CTRL) & dm_data_select_i[0];
  assign ld_new      = dm_load_i & hit;

  // Only a TXDATA push can stall, so the pending latch holds just the byte.
  logic       pend_q;
  logic [7:0] pend_data_q;
  logic       push_req;
  logic [7:0] push_data;
  logic       fifo_push;
  logic       fifo_pop;
  logic       store_accept;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic [LW-1:0] fifo_level;

  assign push_req     = pend_q | st_push_req;
  assign push_data    = pend_q ? pend_data_q : dm_data_s_i[7:0];
  // A pop in the same cycle frees the slot the push needs.
  assign fifo_push    = push_req & (~fifo_full | fifo_pop);
  assign store_accept = (st_new & ~st_push_req) | fifo_push;

  urv_sync_fifo #(
    .g_width (8),
    .g_depth (g_fifo_depth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n),
    .push_i  (fifo_push),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Store handshake, pending latch and CTRL register
  logic irq_en_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dm_store_done_o <= 1'b0;
      pend_q          <= 1'b0;
      pend_data_q     <= 8'h00;
      irq_en_q        <= 1'b0;
    end else begin
      dm_store_done_o <= store_accept;
      pend_q          <= push_req & ~fifo_push;
      if (st_push_req) begin
        pend_data_q <= dm_data_s_i[7:0];
      end
      if (ctrl_wr) begin
        irq_en_q <= dm_data_s_i[0];
      end
    end
  end

  // Serializer state and read-back data
  ser_state_t state_q;
  ser_state_t state_d;
  logic [BW-1:0] baud_q;
  logic [BW-1:0] baud_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          busy;

  assign busy = (state_q != IDLE);

  // STATUS level shows depth-256-when-full as 255.
  logic [8:0]  level_ext;
  logic [7:0]  level_sat;
  logic [31:0] status_word;
  logic [31:0] rd_data;

  assign level_ext = 9'(fifo_level);
  assign level_sat = level_ext[8] ? 8'hFF : level_ext[7:0];

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY_BIT]                  = busy;
    status_word[STATUS_FULL_BIT]                  = fifo_full;
    status_word[STATUS_EMPTY_BIT]                 = fifo_empty;
    status_word[STATUS_LEVEL_LSB +: 8]            = level_sat;
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      REG_STATUS: rd_data = status_word;
      REG_CTRL:   rd_data[CTRL_IRQ_EN_BIT] = irq_en_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dm_load_done_o <= 1'b0;
      dm_data_l_o    <= '0;
    end else begin
      dm_load_done_o <= ld_new;
      if (ld_new) begin
        dm_data_l_o <= rd_data;
      end
    end
  end

  // Serializer register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Serializer next state; the baud counter reloads on every state entry
  // and every data bit, and the state advances when it reaches zero.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          baud_d   = BAUD_LAST;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          state_d = IDLE;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line output decodes straight from the state register so reset drives
  // the line high without waiting for a clock edge.
  assign txd_o = (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shift_q[0] : 1'b1;

  // Registered interrupt
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= irq_en_q & fifo_empty & ~busy;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{dm_data_s_i[31:8], dm_data_select_i[3:1]};

endmodule

// File: tb/tb_urv_console_uart.sv
// Self-checking bench for urv_console_uart (baud divisor 4, FIFO depth 4).
//
// A cycle-level reference model keeps the TX FIFO as a queue and the line
// as "frame in flight since cycle N", and derives every output from that.
module tb_urv_console_uart;

  localparam int          DIV   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0010_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_s;
  logic [3:0]  dm_sel;
  logic        dm_store;
  logic        dm_load;
  logic [31:0] dm_data_l;
  logic        store_done;
  logic        load_done;
  logic        txd;
  logic        irq;

  urv_console_uart #(
    .g_base_addr  (BASE),
    .g_fifo_depth (DEPTH),
    .g_baud_div   (DIV)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .dm_addr_i        (dm_addr),
    .dm_data_s_i      (dm_data_s),
    .dm_data_select_i (dm_sel),
    .dm_store_i       (dm_store),
    .dm_load_i        (dm_load),
    .dm_data_l_o      (dm_data_l),
    .dm_store_done_o  (store_done),
    .dm_load_done_o   (load_done),
    .txd_o            (txd),
    .irq_o            (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  txq[$];
  int          cyc;
  bit          frame_on;
  int          frame_start;
  logic [7:0]  frame_byte;
  bit          pend;
  logic [7:0]  pend_data;
  bit          ctrl_en;
  bit          exp_sdone;
  bit          exp_ldone;
  bit          exp_irq;
  logic [31:0] exp_ldata;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, actual, expected);
    end
  endtask

  task automatic modelReset();
    txq.delete();
    cyc       = 0;
    frame_on  = 0;
    pend      = 0;
    ctrl_en   = 0;
    exp_sdone = 0;
    exp_ldone = 0;
    exp_irq   = 0;
    exp_ldata = '0;
  endtask

  // Line level for the current cycle: start bit, 8 data bits LSB first, stop.
  function automatic logic expTxd();
    int slot;
    if (!frame_on) return 1'b1;
    slot = (cyc - frame_start) / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return frame_byte[slot-1];
    return 1'b1;
  endfunction

  task automatic modelStep(input bit st, input bit ld, input logic [3:0] off,
                           input logic [31:0] data, input logic [3:0] sel);
    bit         busy, empty, full, pop, valid, is_push, accept;
    logic [7:0] lvl8;
    logic [7:0] pdata;
    busy  = frame_on;
    empty = (txq.size() == 0);
    full  = (txq.size() == DEPTH);
    lvl8  = (txq.size() > 255) ? 8'hFF : 8'(txq.size());
    exp_ldone = ld;
    if (ld) begin
      case (off)
        4'h4:    exp_ldata = {16'h0, lvl8, 5'b0, empty, full, busy};
        4'h8:    exp_ldata = {31'b0, ctrl_en};
        default: exp_ldata = 32'h0;
      endcase
    end
    exp_irq = ctrl_en && empty && !busy;
    pop     = !busy && !empty;
    valid   = pend || st;
    is_push = pend || (st && off == 4'h0 && sel[0]);
    pdata   = pend ? pend_data : data[7:0];
    accept  = valid && (!is_push || !full || pop);
    exp_sdone = accept;
    if (pop) begin
      frame_byte  = txq.pop_front();
      frame_on    = 1;
      frame_start = cyc + 1;
    end
    if (accept && is_push) txq.push_back(pdata);
    if (accept && st && off == 4'h8 && sel[0]) ctrl_en = data[0];
    if (valid && !accept && st) pend_data = data[7:0];
    pend = valid && !accept;
    cyc++;
  endtask

  // Drive one bus cycle, check the DUT against the model mid-cycle, advance.
  task automatic applyStimulus(input bit st, input bit ld, input logic [3:0] off,
                               input logic [31:0] data, input logic [3:0] sel);
    dm_store  = st;
    dm_load   = ld;
    dm_addr   = BASE | {28'h0, off};
    dm_data_s = data;
    dm_sel    = sel;
    if (frame_on && cyc >= frame_start + 10*DIV) frame_on = 0;
    @(negedge clk);
    checkOutput("txd", {31'b0, txd}, {31'b0, expTxd()});
    checkOutput("store_done", {31'b0, store_done}, {31'b0, exp_sdone});
    checkOutput("load_done", {31'b0, load_done}, {31'b0, exp_ldone});
    checkOutput("load_data", dm_data_l, exp_ldata);
    checkOutput("irq", {31'b0, irq}, {31'b0, exp_irq});
    modelStep(st, ld, off, data, sel);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    modelReset();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [39:0] samples;
    logic [39:0] exp_frame;
    logic [9:0]  seq55;

    rst_n    = 1'b0;
    dm_store = 0;
    dm_load  = 0;
    dm_addr  = '0;
    dm_data_s = '0;
    dm_sel   = '0;
    cyc      = 0;
    #12;
    checkOutput("reset_txd", {31'b0, txd}, 32'h1);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("reset_store_done", {31'b0, store_done}, 32'h0);
    checkOutput("reset_load_done", {31'b0, load_done}, 32'h0);
    checkOutput("reset_load_data", dm_data_l, 32'h0);
    #20;
    releaseReset();

    // Single byte 0x55: capture the line from two cycles after the strobe.
    seq55 = 10'b1010101010;
    for (int j = 0; j < 40; j++) exp_frame[j] = seq55[j/DIV];
    applyStimulus(1, 0, 4'h0, 32'h55, 4'hF);
    for (int i = 1; i <= 44; i++) begin
      if (i >= 2 && i <= 41) samples[i-2] = txd;
      idle(1);
    end
    checkOutput("frame55_lo", samples[31:0], exp_frame[31:0]);
    checkOutput("frame55_hi", {24'h0, samples[39:32]}, {24'h0, exp_frame[39:32]});
    applyStimulus(0, 1, 4'h4, 32'h0, 4'h0);
    checkOutput("status_after_frame", dm_data_l, 32'h0000_0004);
    idle(2);

    // Interrupt enable, then a byte that drains.
    applyStimulus(1, 0, 4'h8, 32'h1, 4'hF);
    idle(3);
    applyStimulus(1, 0, 4'h0, 32'h00, 4'hF);
    idle(46);

    // Back-to-back stores overrunning the FIFO; the last one must stall.
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 100 && pend; w++) idle(1);
      applyStimulus(1, 0, 4'h0, 32'h41 + i, 4'hF);
      if (i == 4) applyStimulus(0, 1, 4'h4, 32'h0, 4'h0);
    end
    idle(6*(10*DIV+1) + 10);

    // Reset in the middle of a data bit with bytes still queued.
    applyStimulus(1, 0, 4'h0, 32'hA5, 4'hF);
    applyStimulus(1, 0, 4'h0, 32'h11, 4'hF);
    applyStimulus(1, 0, 4'h0, 32'h22, 4'hF);
    idle(12);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("txd_async_reset", {31'b0, txd}, 32'h1);
    dm_store = 0;
    dm_load  = 0;
    repeat (2) @(posedge clk);
    releaseReset();
    applyStimulus(0, 1, 4'h4, 32'h0, 4'h0);
    checkOutput("status_after_reset", dm_data_l, 32'h0000_0004);
    applyStimulus(0, 1, 4'h8, 32'h0, 4'h0);
    checkOutput("ctrl_after_reset", dm_data_l, 32'h0);
    idle(60);

    // Lane 0 unselected, reserved register write and read.
    applyStimulus(1, 0, 4'h0, 32'h77, 4'b0010);
    applyStimulus(1, 0, 4'hC, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(0, 1, 4'hC, 32'h0, 4'h0);
    applyStimulus(0, 1, 4'h4, 32'h0, 4'h0);
    idle(2);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      int r;
      logic [3:0] roff;
      r = $urandom_range(0, 99);
      if (!pend && r < 30) begin
        applyStimulus(1, 0, 4'h0, $urandom, ($urandom_range(0, 7) == 0) ? 4'b1110 : 4'hF);
      end else if (!pend && r < 34) begin
        applyStimulus(1, 0, 4'h8, 32'($urandom_range(0, 1)), 4'hF);
      end else if (!pend && r < 36) begin
        applyStimulus(1, 0, 4'hC, $urandom, 4'hF);
      end else if (r < 50) begin
        roff = 4'($urandom_range(0, 3)) << 2;
        applyStimulus(0, 1, roff, 32'h0, 4'h0);
      end else begin
        idle(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
